// File: rtl/sdram_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, filled through
// the paired-16-bit instruction read mode of an SDRAM controller.
module sdram_icache #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [22:0] f_addr,
  output logic        f_ready,
  output logic        f_valid,
  output logic [31:0] f_data,
  input  logic        flush,
  output logic [22:0] m_addr,
  output logic        m_read_req,
  output logic        m_instr_mode,
  input  logic        m_busy,
  input  logic        m_cack,
  input  logic        m_read_ready,
  input  logic [31:0] m_data
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 23 - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state_q;
  logic             ready_q;
  logic             req_q;
  logic             pend_q;
  logic             low_seen_q;
  logic             f_valid_q;
  logic [31:0]      f_data_q;
  logic [31:0]      fill_q;
  logic [22:0]      addr_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic             capture;

  assign idx      = f_addr[IDX_W-1:0];
  assign fill_idx = addr_q[IDX_W-1:0];
  assign hit      = valid_q[idx] && (tag_q[idx] == f_addr[22:IDX_W]);
  // Fill data is taken only after ready has been seen low inside WAIT, so a
  // ready level left over from the previous transfer is never mistaken for ours.
  assign capture  = (state_q == WAIT) && m_read_ready && low_seen_q;

  assign f_ready      = ready_q & ~flush;
  assign f_valid      = f_valid_q;
  assign f_data       = f_data_q;
  assign m_addr       = addr_q;
  assign m_read_req   = req_q & ~m_busy;
  assign m_instr_mode = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      req_q      <= 1'b0;
      pend_q     <= 1'b0;
      low_seen_q <= 1'b0;
      f_valid_q  <= 1'b0;
      f_data_q   <= '0;
      fill_q     <= '0;
      addr_q     <= '0;
      valid_q    <= '0;
    end else begin
      f_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (flush) begin
            valid_q <= '0;
          end else if (ready_q && f_req) begin
            if (hit) begin
              f_valid_q <= 1'b1;
              f_data_q  <= data_q[idx];
            end else begin
              addr_q  <= f_addr;
              req_q   <= 1'b1;
              ready_q <= 1'b0;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) pend_q <= 1'b1;
          if (m_cack) begin
            req_q      <= 1'b0;
            low_seen_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (!m_read_ready) low_seen_q <= 1'b1;
          if (capture) begin
            fill_q  <= m_data;
            pend_q  <= 1'b0;
            state_q <= RESP;
            // A flush seen during the fill invalidates everything, this line included.
            if (pend_q || flush) valid_q <= '0;
            else                 valid_q[fill_idx] <= 1'b1;
          end else if (flush) begin
            pend_q <= 1'b1;
          end
        end
        RESP: begin
          f_valid_q <= 1'b1;
          f_data_q  <= fill_q;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
          if (flush) valid_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tags and data need no reset: the valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (capture) begin
      tag_q[fill_idx]  <= addr_q[22:IDX_W];
      data_q[fill_idx] <= m_data;
    end
  end

endmodule

// File: tb/tb_sdram_icache.sv
// Randomised and directed bench for sdram_icache with an SDRAM controller
// model, an address-level cache model and a scoreboard-driven monitor.
module tb_sdram_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [22:0] f_addr;
  logic        f_ready;
  logic        f_valid;
  logic [31:0] f_data;
  logic        flush;
  logic [22:0] m_addr;
  logic        m_read_req;
  logic        m_instr_mode;
  logic        m_busy;
  logic        m_cack;
  logic        m_read_ready;
  logic [31:0] m_data;

  sdram_icache #(.IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .f_req(f_req), .f_addr(f_addr),
    .f_ready(f_ready), .f_valid(f_valid), .f_data(f_data), .flush(flush),
    .m_addr(m_addr), .m_read_req(m_read_req), .m_instr_mode(m_instr_mode),
    .m_busy(m_busy), .m_cack(m_cack), .m_read_ready(m_read_ready),
    .m_data(m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          hit;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [22:0] cached[int];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_ready_cyc = -100;
  int          last_acc = 0;
  int          req_cycles = 0;
  logic [22:0] exp_maddr = '0;
  bit          rnd_mode = 0;
  bit          sticky = 0;
  int          ack_d = 2;
  int          dat_d = 5;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem(input logic [22:0] a);
    if (a == 23'h000040) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Controller model: acks after ack_d cycles, then drops ready for one cycle
  // and raises it with data; in sticky mode ready is left high afterwards.
  initial begin
    logic [22:0] a;
    m_busy = 1'b0; m_cack = 1'b0; m_read_ready = 1'b0; m_data = '0;
    forever begin
      @(negedge clk);
      m_busy = rnd_mode && ($urandom_range(0, 3) == 0);
      #2;
      if (m_read_req && rst_n) begin
        chk("m_addr", 32'(m_addr), 32'(exp_maddr));
        a = m_addr;
        if (rnd_mode) begin
          ack_d = $urandom_range(0, 3);
          dat_d = $urandom_range(1, 6);
        end
        repeat (ack_d) @(negedge clk);
        m_cack = 1'b1;
        @(negedge clk);
        m_cack = 1'b0;
        repeat (dat_d - 1) @(negedge clk);
        m_read_ready = 1'b0;
        @(negedge clk);
        m_data = mem(a);
        m_read_ready = 1'b1;
        last_ready_cyc = cyc;
        @(negedge clk);
        if (!sticky) m_read_ready = 1'b0;
      end
    end
  end

  // Monitor: every f_valid must match the oldest outstanding fetch.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst_n) begin
      if (m_read_req) req_cycles++;
      if (m_busy) chk("req_while_busy", 32'(m_read_req), 32'd0);
      if (f_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_fvalid: got data %h with no fetch outstanding (cycle %0d)", f_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("fetch_data", f_data, e.d);
          if (e.hit) chk("hit_latency", 32'(cyc), 32'(e.acc + 1));
          else       chk("miss_latency", 32'(cyc), 32'(last_ready_cyc + 2));
        end
      end
    end
  end

  task automatic fetch(input logic [22:0] a);
    int t = 0;
    exp_t e;
    int i;
    @(negedge clk);
    f_req = 1'b1;
    f_addr = a;
    #1;
    while (!f_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!f_ready) begin
      chk("fetch_accept_timeout", 32'(f_ready), 32'd1);
    end else begin
      i = int'(a[5:0]);
      e.d = mem(a);
      e.hit = cached.exists(i) && (cached[i] == a);
      e.acc = cyc;
      last_acc = cyc;
      if (!e.hit) begin
        cached[i] = a;
        exp_maddr = a;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    f_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cack();
    int t = 0;
    while (t < 50) begin
      @(negedge clk);
      #1;
      if (m_cack) break;
      t++;
    end
    chk("cack_seen", 32'(m_cack), 32'd1);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cached.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_f_valid"}, 32'(f_valid), 32'd0);
    chk({tag, "_f_data"}, f_data, 32'd0);
    chk({tag, "_m_read_req"}, 32'(m_read_req), 32'd0);
    chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_f_ready"}, 32'(f_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    chk("instr_mode", 32'(m_instr_mode), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(f_ready), 32'd0);

    // Cold miss with fixed controller timing.
    req_cycles = 0;
    fetch(23'h000040);
    drain();
    chk("req_cycle_count", 32'(req_cycles), 32'd3);

    // Hit, miss on a neighbour, hit again; then back-to-back hits.
    fetch(23'h000040);
    fetch(23'h000041);
    fetch(23'h000040);
    a0 = last_acc;
    fetch(23'h000040);
    chk("b2b_hit_rate", 32'(last_acc - a0), 32'd1);
    drain();

    // Index conflict evicts the earlier line.
    fetch(23'h000080);
    fetch(23'h000040);
    drain();

    // Flush pulse while the fill is outstanding.
    fetch(23'h000123);
    wait_cack();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cached.delete();
    drain();
    fetch(23'h000123);
    fetch(23'h000041);
    drain();

    // Flush and request together: flush wins, nothing is accepted.
    @(negedge clk);
    flush = 1'b1; f_req = 1'b1; f_addr = 23'h000041;
    #1;
    chk("flush_blocks_ready", 32'(f_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; f_req = 1'b0;
    cached.delete();
    repeat (3) @(negedge clk);
    fetch(23'h000041);
    drain();

    // Stale ready level at WAIT entry must not be captured.
    sticky = 1;
    fetch(23'h000200);
    drain();
    fetch(23'h000305);
    drain();
    sticky = 0;
    repeat (3) @(negedge clk);

    // Reset during WAIT, late ready afterwards.
    fetch(23'h000055);
    wait_cack();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    cached.delete();
    #1;
    check_reset_outputs("midmiss_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    fetch(23'h000055);
    drain();

    // Randomised traffic over a small conflicting address pool.
    rnd_mode = 1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) flush_idle();
      else fetch(23'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7)));
    end
    drain();
    rnd_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_icache.md
SDRAM_ICACHE -- requirements
Module: sdram_icache

Interface
REQ-001 Parameter: IDX_W, default 6, index width; the cache holds 2^IDX_W lines of one 32-bit instruction each.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 f_req  in  1  CPU fetch request; accepted only in a cycle where f_ready=1.
REQ-005 f_addr  in  23  instruction word address; sampled on acceptance.
REQ-006 f_ready  out  1  cache can accept a fetch this cycle.
REQ-007 f_valid  out  1  one-cycle pulse; f_data holds the fetched instruction.
REQ-008 f_data  out  32  instruction; {high word, low word} as delivered by the SDRAM controller.
REQ-009 flush  in  1  one-cycle pulse; invalidates all lines.
REQ-010 m_addr  out  23  address to the SDRAM controller.
REQ-011 m_read_req  out  1  read request to the SDRAM controller.
REQ-012 m_instr_mode  out  1  constant 1; selects paired 16-bit instruction reads.
REQ-013 m_busy, m_cack, m_read_ready  in  1 each  controller status, acknowledge and data-ready.
REQ-014 m_data  in  32  controller read data.

Function
REQ-015 Storage: per line, one valid bit, a tag = f_addr[22:IDX_W] and 32 bits of data; index = f_addr[IDX_W-1:0].
REQ-016 FSM states: IDLE, REQ, WAIT, RESP.
REQ-017 f_ready=1 only in IDLE with no flush pulse in the same cycle.
REQ-018 Hit (IDLE, accepted, line valid, tag equal):
- next cycle, f_valid=1 and f_data=line data;
- FSM stays in IDLE;
- back-to-back hits sustain 1 fetch/cycle.
REQ-019 Miss (accepted, line invalid or tag mismatch):
- latch address;
- go to REQ next cycle;
- no f_valid for this fetch until the fill completes.
REQ-020 REQ:
- m_read_req=1 and m_addr=latched address while m_busy=0;
- remain in REQ until m_cack=1, then go to WAIT;
- m_read_req deasserts in the cycle after m_cack.
REQ-021 WAIT: on the first cycle with m_read_ready=1, capture m_data into the line, set its valid bit and tag, then go to RESP.
REQ-022 RESP:
- f_valid=1 and f_data=captured data for one cycle;
- return to IDLE;
- f_ready is 0 throughout REQ, WAIT and RESP.
REQ-023 Miss latency: f_valid occurs exactly 2 cycles after the cycle in which m_read_ready is first seen high.
REQ-024 m_read_ready already high on WAIT entry (stale from a previous access) is ignored until it has been observed low at least once.
REQ-025 Flush in IDLE clears all valid bits in one cycle. Flush and f_req in the same cycle: flush wins and the request is not accepted.
REQ-026 Flush during REQ or WAIT:
- recorded as pending;
- the fill still returns data to the CPU but is not marked valid;
- all valid bits clear when the FSM enters RESP.
REQ-027 Outputs are registered; f_data holds its last value when f_valid=0.

Reset
REQ-028 While rst_n=0:
- FSM=IDLE, all valid bits=0, flush pending=0;
- f_valid=0, f_data=0;
- m_read_req=0, m_addr=0;
- f_ready=0 for the first cycle after release.
REQ-029 Reset mid-miss abandons the fill. A later m_read_ready from the controller is ignored unless the FSM is in WAIT.
REQ-030 Tag and data arrays need no reset; valid bits gate all hits.

Verification
REQ-031 Cold fetch 0x000040: controller model acks after 2 cycles and returns 0xDEADBEEF 5 cycles later -> exactly one m_read_req cycle sequence; f_valid with 0xDEADBEEF 2 cycles after m_read_ready.
REQ-032 Refetch 0x000040, then 0x000041 and 0x000040 back-to-back -> the first and third hit (f_valid next cycle); 0x000041 misses.
REQ-033 Conflict: fetch 0x000040, then 0x000080 (same index, IDX_W=6) -> both miss; a third fetch of 0x000040 misses again.
REQ-034 Flush pulse during WAIT of a miss -> the CPU receives the data; an immediate refetch of the same address misses.
REQ-035 m_read_ready held high from the previous access at WAIT entry -> no capture until a low-then-high transition; data is correct.
REQ-036 rst_n low during WAIT, then a late m_read_ready -> no f_valid and no valid bit set; the first fetch after reset misses.
